regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Synthesizable run monitor that watches the pipelined processor's write-back port and program counter, keeps a shadow copy of the architectural register file, and after a run terminates compares up to NCHK programmed registers against expected values. It sits beside `Top`, tapping PC and the WB-stage register-write signals, and replaces fixed-cycle `$display` checks with a parametrised cycle budget, end-PC termination and a pass/fail verdict.

## Interface
- DATA_W, 32, register/PC data width
- ADDR_W, 5, register address width (NREG = 2**ADDR_W)
- NCHK, 4, number of expected-value table entries
- CYC_W, 32, cycle counter width
- HANG_LIMIT, 16, cycles of unchanged PC that flag a hang (HANG_DETECT_EN only)

- clk  in  1  processor clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  arm a run; sampled in IDLE or DONE only
- cycle_limit  in  CYC_W  run budget, sampled on start; 0 = unlimited
- end_pc  in  DATA_W  terminating PC, sampled on start
- pc  in  DATA_W  processor program counter
- wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  register-file write port
- exp_wr  in  1  write expected-table entry (ignored unless IDLE or DONE)
- exp_idx  in  $clog2(NCHK)  table entry index
- exp_reg / exp_val  in  ADDR_W / DATA_W  register to check, expected value
- busy  out  1  RUN or CHECK
- done  out  1  verdict valid, held until next start or reset
- pass  out  1  done and zero mismatches and no hang
- fail_count  out  $clog2(NCHK+1)  mismatching valid entries
- first_fail_idx  out  $clog2(NCHK)  lowest failing entry index
- cycle_count  out  CYC_W  cycles spent in RUN
- hang  out  1  hang detected during the run

## Operation
- States: IDLE -> RUN -> CHECK -> DONE; DONE -> RUN on start.
- Reset: state IDLE; all outputs 0; shadow registers 0; all table entries invalid.
- exp_wr writes entry exp_idx and marks it valid; entries persist across runs until reset.
- start: latch cycle_limit/end_pc, clear cycle_count, fail_count, first_fail_idx, hang, done, pass; go RUN. Shadow file is NOT cleared (mirrors processor registers).
- RUN: cycle_count += 1 each cycle (saturates at all-ones). Exit to CHECK when pc == end_pc, or cycle_count+1 == cycle_limit (limit ≠ 0), or hang; multiple causes same cycle -> single exit.
- Shadow write on wb_en && wb_addr != 0 in any state except CHECK; register 0 always reads 0. A writeback in the exit cycle is captured.
- CHECK: one entry per cycle, idx 0..NCHK-1; invalid entries skipped but still take a cycle. Mismatch: fail_count += 1; first_fail_idx set on first mismatch only.
- DONE: done=1, pass as defined; start ignored in CHECK and RUN.

## Timing
- start at edge T -> busy=1 from T+1.
- Exit condition true in cycle E -> CHECK from E+1, done=1 at E+1+NCHK.
- cycle_limit = L -> run ends with cycle_count = L.
- Shadow write visible to CHECK comparison one cycle after the wb_en cycle.
- rst_n low mid-run: next edge returns IDLE, verdict and table cleared.

## Configuration
- HANG_DETECT_EN defined: counter tracks cycles with pc unchanged in RUN; reaching HANG_LIMIT sets hang=1 and ends RUN; pass forced 0.
- Not defined: no counter; hang tied 0; run ends only by end_pc or cycle_limit.

## Test plan
- Program entries {19:0, 20:10, 21:15}, start with cycle_limit=55, drive WB writes r19=0, r20=10, r21=15 -> done at cycle 55+1+NCHK, pass=1, fail_count=0, cycle_count=55.
- Same but r20=11 -> pass=0, fail_count=1, first_fail_idx=1.
- end_pc=400, cycle_limit=0, pc reaches 400 at run cycle 12 -> cycle_count=12, done 4 cycles later.
- wb_en with wb_addr=0, data=0xFFFF, entry {0:0} -> pass=1.
- HANG_DETECT_EN, HANG_LIMIT=16, pc frozen -> hang=1, pass=0 after 16 stalled cycles; without macro, runs to cycle_limit.
- rst_n low during CHECK -> next cycle busy=0, done=0; start then runs with all entries invalid -> pass=1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Run monitor: shadows the register file from the write-back port, bounds a run by end PC /
// cycle budget, then checks up to NCHK programmed registers. Optional hang detector: HANG_DETECT_EN.
module regfile_scoreboard #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NCHK       = 4,
    parameter int CYC_W      = 32,
    parameter int HANG_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CYC_W-1:0]           cycle_limit,
    input  logic [DATA_W-1:0]          end_pc,
    input  logic [DATA_W-1:0]          pc,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       exp_wr,
    input  logic [$clog2(NCHK)-1:0]    exp_idx,
    input  logic [ADDR_W-1:0]          exp_reg,
    input  logic [DATA_W-1:0]          exp_val,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(NCHK+1)-1:0]  fail_count,
    output logic [$clog2(NCHK)-1:0]    first_fail_idx,
    output logic [CYC_W-1:0]           cycle_count,
    output logic                       hang
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int IDX_W = $clog2(NCHK);
    localparam int FC_W  = $clog2(NCHK + 1);
    localparam logic [CYC_W:0] ONE_EXT = 1;

    if (NCHK < 2) begin : g_bad_nchk
        $error("regfile_scoreboard: NCHK must be at least 2");
    end
    if (HANG_LIMIT < 1) begin : g_bad_hang
        $error("regfile_scoreboard: HANG_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CYC_W-1:0]    cycle_limit_q, cycle_limit_d;
    logic [DATA_W-1:0]   end_pc_q, end_pc_d;
    logic [CYC_W-1:0]    cycle_count_q, cycle_count_d;
    logic [FC_W-1:0]     fail_count_q, fail_count_d;
    logic [IDX_W-1:0]    first_fail_idx_q, first_fail_idx_d;
    logic [IDX_W-1:0]    chk_idx_q, chk_idx_d;
    logic                hang_q, hang_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic [NCHK-1:0]     exp_valid_q, exp_valid_d;
    logic [ADDR_W-1:0]   exp_reg_q [NCHK];
    logic [ADDR_W-1:0]   exp_reg_d [NCHK];
    logic [DATA_W-1:0]   exp_val_q [NCHK];
    logic [DATA_W-1:0]   exp_val_d [NCHK];

    logic [DATA_W-1:0]   shadow_q [NREG];
    logic [DATA_W-1:0]   shadow_d [NREG];

    logic                can_arm;
    logic                hang_hit;
    logic                run_exit;
    logic                chk_mismatch;
    logic [CYC_W:0]      cnt_ext;

    assign can_arm = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cnt_ext = {1'b0, cycle_count_q} + ONE_EXT;

`ifdef HANG_DETECT_EN
    localparam int HCNT_W = $clog2(HANG_LIMIT + 1);

    logic [DATA_W-1:0]   pc_prev_q, pc_prev_d;
    logic [HCNT_W-1:0]   stall_q, stall_d;

    // Stall run length restarts whenever the PC moves or the monitor leaves RUN.
    always_comb begin
        pc_prev_d = pc;
        stall_d   = '0;
        if (state_q == S_RUN && pc == pc_prev_q) begin
            stall_d = stall_q + HCNT_W'(1);
        end
    end

    assign hang_hit = (stall_d == HCNT_W'(HANG_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_prev_q <= '0;
            stall_q   <= '0;
        end else begin
            pc_prev_q <= pc_prev_d;
            stall_q   <= stall_d;
        end
    end
`else
    assign hang_hit = 1'b0;
`endif

    // Register 0 is never written, so it keeps its reset value of zero.
    always_comb begin
        shadow_d = shadow_q;
        if (wb_en && wb_addr != '0 && state_q != S_CHECK) begin
            shadow_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        exp_valid_d = exp_valid_q;
        exp_reg_d   = exp_reg_q;
        exp_val_d   = exp_val_q;
        if (exp_wr && can_arm) begin
            exp_valid_d[exp_idx] = 1'b1;
            exp_reg_d[exp_idx]   = exp_reg;
            exp_val_d[exp_idx]   = exp_val;
        end
    end

    always_comb begin
        state_d          = state_q;
        cycle_limit_d    = cycle_limit_q;
        end_pc_d         = end_pc_q;
        cycle_count_d    = cycle_count_q;
        fail_count_d     = fail_count_q;
        first_fail_idx_d = first_fail_idx_q;
        chk_idx_d        = chk_idx_q;
        hang_d           = hang_q;
        done_d           = done_q;
        pass_d           = pass_q;
        run_exit         = 1'b0;
        chk_mismatch     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cycle_limit_d    = cycle_limit;
                    end_pc_d         = end_pc;
                    cycle_count_d    = '0;
                    fail_count_d     = '0;
                    first_fail_idx_d = '0;
                    chk_idx_d        = '0;
                    hang_d           = 1'b0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    state_d          = S_RUN;
                end
            end
            S_RUN: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CYC_W'(1);
                end
                if (hang_hit) begin
                    hang_d = 1'b1;
                end
                // The count compare looks one ahead so the run stops with cycle_count == limit.
                run_exit = (pc == end_pc_q)
                        || ((cycle_limit_q != '0) && (cnt_ext == {1'b0, cycle_limit_q}))
                        || hang_hit;
                if (run_exit) begin
                    chk_idx_d = '0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                chk_mismatch = exp_valid_q[chk_idx_q]
                            && (shadow_q[exp_reg_q[chk_idx_q]] != exp_val_q[chk_idx_q]);
                if (chk_mismatch) begin
                    fail_count_d = fail_count_q + FC_W'(1);
                    if (fail_count_q == '0) begin
                        first_fail_idx_d = chk_idx_q;
                    end
                end
                if (chk_idx_q == IDX_W'(NCHK - 1)) begin
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == '0) && !hang_q;
                    state_d = S_DONE;
                end else begin
                    chk_idx_d = chk_idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            cycle_limit_q    <= '0;
            end_pc_q         <= '0;
            cycle_count_q    <= '0;
            fail_count_q     <= '0;
            first_fail_idx_q <= '0;
            chk_idx_q        <= '0;
            hang_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            exp_valid_q      <= '0;
            for (int i = 0; i < NCHK; i++) begin
                exp_reg_q[i] <= '0;
                exp_val_q[i] <= '0;
            end
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            cycle_limit_q    <= cycle_limit_d;
            end_pc_q         <= end_pc_d;
            cycle_count_q    <= cycle_count_d;
            fail_count_q     <= fail_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            chk_idx_q        <= chk_idx_d;
            hang_q           <= hang_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            exp_valid_q      <= exp_valid_d;
            exp_reg_q        <= exp_reg_d;
            exp_val_q        <= exp_val_d;
            shadow_q         <= shadow_d;
        end
    end

    assign busy           = (state_q == S_RUN) || (state_q == S_CHECK);
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign cycle_count    = cycle_count_q;
    assign hang           = hang_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: table of runs with hand-computed verdicts plus
// sequences for in-run writes, frozen PC and reset during CHECK.
module tb_regfile_scoreboard;

    localparam int NCHK = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] cycle_limit;
    logic [31:0] end_pc;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exp_wr;
    logic [1:0]  exp_idx;
    logic [4:0]  exp_reg;
    logic [31:0] exp_val;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  fail_count;
    logic [1:0]  first_fail_idx;
    logic [31:0] cycle_count;
    logic        hang;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cycle_limit(cycle_limit),
        .end_pc(end_pc), .pc(pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .exp_wr(exp_wr), .exp_idx(exp_idx), .exp_reg(exp_reg), .exp_val(exp_val),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .cycle_count(cycle_count), .hang(hang)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int          limit;
        logic [31:0] endpc;
        int          pc_hit;
        logic [31:0] d19;
        logic [31:0] d20;
        logic [31:0] d21;
        bit          e_pass;
        int          e_fc;
        int          e_ffi;
        int          e_cc;
        int          e_edges;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    task automatic prog(input logic [1:0] i, input logic [4:0] r, input logic [31:0] v);
        exp_wr  = 1'b1;
        exp_idx = i;
        exp_reg = r;
        exp_val = v;
        tick();
        exp_wr  = 1'b0;
    endtask

    // n = number of edges after the start edge until done is seen.
    task automatic do_run(input int limit, input logic [31:0] ep, input int pc_hit,
                          input bit frozen, output int n);
        int k;
        cycle_limit = limit;
        end_pc      = ep;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        n = 0;
        while (!done && n < 500) begin
            k = n + 1;
            if (frozen)           pc = 32'h2000;
            else if (k == pc_hit) pc = ep;
            else                  pc = 32'h1000 + 32'(4 * k);
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int k;

        vecs[0] = '{55, 32'hDEAD0000,  0, 0, 10, 15, 1, 0, 0, 55, 59};
        vecs[1] = '{55, 32'hDEAD0000,  0, 0, 11, 15, 0, 1, 1, 55, 59};
        vecs[2] = '{ 0, 32'd400,      12, 0, 10, 15, 1, 0, 0, 12, 16};
        vecs[3] = '{20, 32'hDEAD0000,  0, 0,  9, 16, 0, 2, 1, 20, 24};
        vecs[4] = '{ 1, 32'hDEAD0000,  0, 0, 10, 15, 1, 0, 0,  1,  5};
        vecs[5] = '{30, 32'd400,      30, 0, 10, 15, 1, 0, 0, 30, 34};
        vecs[6] = '{ 0, 32'd400,       1, 0, 10, 15, 1, 0, 0,  1,  5};
        vecs[7] = '{ 8, 32'hDEAD0000,  0, 0, 10, 14, 0, 1, 2,  8, 12};
        vecs[8] = '{ 2, 32'hDEAD0000,  0, 1, 11, 16, 0, 3, 0,  2,  6};

        rst_n = 1'b0; start = 1'b0; cycle_limit = '0; end_pc = '0; pc = 32'h1000;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        exp_wr = 1'b0; exp_idx = '0; exp_reg = '0; exp_val = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_count", fail_count, 0);
        chk("rst_first_fail", first_fail_idx, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_hang", hang, 0);
        rst_n = 1'b1;
        tick();

        prog(2'd0, 5'd19, 32'd0);
        prog(2'd1, 5'd20, 32'd10);
        prog(2'd2, 5'd21, 32'd15);
        prog(2'd3, 5'd0,  32'd0);

        for (int v = 0; v < 9; v++) begin
            wb_write(5'd19, vecs[v].d19);
            wb_write(5'd20, vecs[v].d20);
            wb_write(5'd21, vecs[v].d21);
            wb_write(5'd0,  32'hFFFF);
            do_run(vecs[v].limit, vecs[v].endpc, vecs[v].pc_hit, 1'b0, n);
            $display("vec %0d limit=%0d pass=%0b fc=%0d ffi=%0d cc=%0d edges=%0d",
                     v, vecs[v].limit, pass, fail_count, first_fail_idx, cycle_count, n);
            chk($sformatf("v%0d_edges", v), n, vecs[v].e_edges);
            chk($sformatf("v%0d_pass", v), pass, vecs[v].e_pass);
            chk($sformatf("v%0d_fail_count", v), fail_count, vecs[v].e_fc);
            chk($sformatf("v%0d_first_fail", v), first_fail_idx, vecs[v].e_ffi);
            chk($sformatf("v%0d_cycle_count", v), cycle_count, vecs[v].e_cc);
            chk($sformatf("v%0d_hang", v), hang, 0);
            chk($sformatf("v%0d_busy_done", v), busy, 0);
        end

        // Writes during RUN, exit-cycle capture, blocked CHECK write, ignored start/exp_wr.
        cycle_limit = 10;
        end_pc      = 32'hDEAD0000;
        start       = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 500) begin
            k       = n + 1;
            pc      = 32'h1000 + 32'(4 * k);
            wb_en   = (k == 2) || (k == 3) || (k == 10) || (k == 11);
            wb_addr = (k == 2) ? 5'd19 : (k == 3) ? 5'd20 : 5'd21;
            wb_data = (k == 2) ? 32'd0 : (k == 3) ? 32'd10 : (k == 10) ? 32'd15 : 32'd99;
            start   = (k == 5);
            exp_wr  = (k == 5);
            exp_idx = 2'd1;
            exp_reg = 5'd20;
            exp_val = 32'd99;
            tick();
            n++;
        end
        wb_en = 1'b0; start = 1'b0; exp_wr = 1'b0;
        $display("seq runwrites pass=%0b fc=%0d cc=%0d edges=%0d", pass, fail_count, cycle_count, n);
        chk("rw_edges", n, 14);
        chk("rw_cycle_count", cycle_count, 10);
        chk("rw_pass", pass, 1);
        chk("rw_fail_count", fail_count, 0);

        // Frozen PC.
        pc = 32'h2000;
        do_run(40, 32'hDEAD0000, 0, 1'b1, n);
        $display("seq frozen pass=%0b hang=%0b cc=%0d edges=%0d", pass, hang, cycle_count, n);
`ifdef HANG_DETECT_EN
        chk("fz_edges", n, 20);
        chk("fz_cycle_count", cycle_count, 16);
        chk("fz_hang", hang, 1);
        chk("fz_pass", pass, 0);
`else
        chk("fz_edges", n, 44);
        chk("fz_cycle_count", cycle_count, 40);
        chk("fz_hang", hang, 0);
        chk("fz_pass", pass, 1);
`endif

        // Reset asserted during CHECK clears verdict and table.
        cycle_limit = 5;
        end_pc      = 32'hDEAD0000;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            tick();
        end
        chk("rc_busy_in_check", busy, 1);
        chk("rc_done_in_check", done, 0);
        rst_n = 1'b0;
        tick();
        $display("seq reset_in_check busy=%0b done=%0b cc=%0d", busy, done, cycle_count);
        chk("rc_busy_after_rst", busy, 0);
        chk("rc_done_after_rst", done, 0);
        chk("rc_cc_after_rst", cycle_count, 0);
        rst_n = 1'b1;
        tick();
        do_run(3, 32'hDEAD0000, 0, 1'b0, n);
        $display("seq post_reset pass=%0b fc=%0d cc=%0d edges=%0d", pass, fail_count, cycle_count, n);
        chk("pr_edges", n, 7);
        chk("pr_pass", pass, 1);
        chk("pr_fail_count", fail_count, 0);
        chk("pr_cycle_count", cycle_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
